// File: rtl/controller_ram_dma.sv
// controller_ram_dma
// Avalon-MM master for the controller's single-port on-chip RAM (s1 port).
// It runs one fill or forward block-copy command at a time. When a command
// finishes, it pulses done for one cycle and reports the modulo-2^32 sum of
// every word it wrote.
//
// Ports:
//   clk, reset           sole clock; synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op               0 = fill, 1 = copy
//   cmd_incr             fill value steps by 1 per word when set
//   cmd_src/cmd_dst      start word addresses (copy source / destination)
//   cmd_len              word count 0..2^ADDR_W
//   cmd_pattern          fill start value
//   busy, done, sum      status; sum holds until the next accepted command
//   avm_*                Avalon-MM master; fixed one-cycle read latency
module controller_ram_dma #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic              cmd_incr,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_pattern,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_CAP, S_WR, S_DONE} state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] src, src_n, dst, dst_n;
    logic [ADDR_W:0]   rem, rem_n;
    logic [DATA_W-1:0] val, val_n;
    logic              incr, incr_n;
    logic [DATA_W-1:0] sum_n;
    logic              cs_n, we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;

    // Every bus output is a flop loaded from the next-cycle values computed
    // here. As a result, the first bus cycle is the cycle right after accept.
    // src/dst/val always hold the address/value currently on the bus.
    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        rem_n   = rem;
        val_n   = val;
        incr_n  = incr;
        cs_n    = 1'b0;
        we_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        // The sum accumulates whatever word is being written this cycle.
        sum_n   = sum + ((avm_chipselect && avm_write) ? avm_writedata : '0);

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_n  = cmd_src;
                    dst_n  = cmd_dst;
                    rem_n  = cmd_len;
                    val_n  = cmd_pattern;
                    incr_n = cmd_incr;
                    sum_n  = '0;
                    if (cmd_len == '0) begin
                        state_n = S_DONE;
                    end else if (!cmd_op) begin
                        state_n = S_FILL;
                        cs_n    = 1'b1;
                        we_n    = 1'b1;
                        addr_n  = cmd_dst;
                        wdata_n = cmd_pattern;
                    end else begin
                        state_n = S_RD;
                        cs_n    = 1'b1;
                        addr_n  = cmd_src;
                    end
                end
            end
            S_FILL: begin
                rem_n = rem - LEN_ONE;
                dst_n = dst + ADDR_ONE;
                val_n = val + {{(DATA_W-1){1'b0}}, incr};
                if (rem == LEN_ONE) begin
                    state_n = S_DONE;
                end else begin
                    cs_n    = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = dst_n;
                    wdata_n = val_n;
                end
            end
            S_RD: begin
                state_n = S_CAP;
            end
            S_CAP: begin
                // Read data is valid now. The writedata register acts as the
                // copy buffer, so the word goes straight onto the bus next cycle.
                state_n = S_WR;
                cs_n    = 1'b1;
                we_n    = 1'b1;
                addr_n  = dst;
                wdata_n = avm_readdata;
            end
            S_WR: begin
                rem_n = rem - LEN_ONE;
                src_n = src + ADDR_ONE;
                dst_n = dst + ADDR_ONE;
                if (rem == LEN_ONE) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_RD;
                    cs_n    = 1'b1;
                    addr_n  = src_n;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            src            <= '0;
            dst            <= '0;
            rem            <= '0;
            val            <= '0;
            incr           <= 1'b0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            sum            <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_address    <= '0;
            avm_writedata  <= '0;
        end else begin
            state          <= state_n;
            src            <= src_n;
            dst            <= dst_n;
            rem            <= rem_n;
            val            <= val_n;
            incr           <= incr_n;
            cmd_ready      <= (state_n == S_IDLE);
            busy           <= (state_n != S_IDLE);
            done           <= (state_n == S_DONE);
            sum            <= sum_n;
            avm_chipselect <= cs_n;
            avm_write      <= we_n;
            avm_byteenable <= cs_n ? 4'hF : 4'h0;
            avm_address    <= addr_n;
            avm_writedata  <= wdata_n;
        end
    end

endmodule

// File: tb/tb_controller_ram_dma.sv
// Bench for controller_ram_dma. A behavioural RAM slave sits on the Avalon
// port. A word-level reference model (a RAM image plus the expected
// write/read lists and sum) is derived from the command rules.
module tb_controller_ram_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_op, cmd_incr;
    logic [11:0] cmd_src, cmd_dst;
    logic [12:0] cmd_len;
    logic [31:0] cmd_pattern;
    logic        busy, done;
    logic [31:0] sum;
    logic [11:0] avm_address;
    logic        avm_chipselect, avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata;

    always #5 clk = ~clk;

    controller_ram_dma #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_incr(cmd_incr), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
        .busy(busy), .done(done), .sum(sum),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    // RAM slave: writes land at the edge; read data is valid the next cycle.
    logic [31:0] ram [4096];
    logic        ram_init;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
        end else if (avm_chipselect) begin
            if (avm_write) ram[avm_address] <= avm_writedata;
            else avm_readdata <= ram[avm_address];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [4096];
    logic [11:0] ex_wa[$], ex_ra[$], wr_addr[$], rd_addr[$];
    logic [31:0] ex_wd[$], wr_data[$];
    logic [31:0] ex_sum;

    // Observations collected by run_cmd.
    byte         kind_log [13000];
    int          done_cyc, ready_cyc, done_cnt, ncyc;
    logic [31:0] sum_at_done, sum_c1;
    bit          timeout;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_cmd(input bit op, input bit incr, input logic [11:0] src,
                             input logic [11:0] dst, input logic [12:0] len,
                             input logic [31:0] pat);
        logic [11:0] a, s;
        logic [31:0] v;
        ex_wa.delete(); ex_wd.delete(); ex_ra.delete();
        ex_sum = 32'h0;
        for (int i = 0; i < int'(len); i++) begin
            a = dst + 12'(i);
            if (!op) begin
                v = pat + (incr ? 32'(i) : 32'h0);
            end else begin
                s = src + 12'(i);
                ex_ra.push_back(s);
                v = ref_mem[s];
            end
            ref_mem[a] = v;
            ex_wa.push_back(a);
            ex_wd.push_back(v);
            ex_sum = ex_sum + v;
        end
    endtask

    // Issue one command and record the bus and status activity for each
    // cycle after accept. With hold set, cmd_valid stays high while busy,
    // and the other command fields are scrambled.
    task automatic run_cmd(input bit op, input bit incr, input logic [11:0] src,
                           input logic [11:0] dst, input logic [12:0] len,
                           input logic [31:0] pat, input bit hold);
        int  k;
        bit  fin;
        byte kd;
        wr_addr.delete(); wr_data.delete(); rd_addr.delete();
        done_cyc = -1; ready_cyc = -1; done_cnt = 0; timeout = 0;
        sum_at_done = 32'h0; sum_c1 = 32'hDEADBEEF;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_incr = incr; cmd_src = src;
        cmd_dst = dst; cmd_len = len; cmd_pattern = pat;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        k = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            k++;
            if (avm_chipselect) kd = (avm_byteenable !== 4'hF) ? "X" : (avm_write ? "W" : "R");
            else kd = (avm_byteenable !== 4'h0 || avm_write) ? "X" : "-";
            kind_log[k] = kd;
            if (k == 1) sum_c1 = sum;
            if (avm_chipselect && avm_write) begin
                wr_addr.push_back(avm_address);
                wr_data.push_back(avm_writedata);
            end
            if (avm_chipselect && !avm_write) rd_addr.push_back(avm_address);
            if (done) begin done_cnt++; done_cyc = k; sum_at_done = sum; end
            if (cmd_ready) begin
                ready_cyc = k; fin = 1; cmd_valid = 1'b0;
            end else if (hold) begin
                cmd_pattern = $urandom; cmd_dst = 12'($urandom);
                cmd_src = 12'($urandom); cmd_len = 13'($urandom); cmd_op = 1'($urandom);
            end
            if (k >= 12500) begin timeout = 1; fin = 1; cmd_valid = 1'b0; end
        end
        ncyc = k;
    endtask

    task automatic test_command(input string name, input bit op, input bit incr,
                                input logic [11:0] src, input logic [11:0] dst,
                                input logic [12:0] len, input logic [31:0] pat,
                                input bit hold);
        int  errs, exp_done;
        byte ek;
        model_cmd(op, incr, src, dst, len, pat);
        run_cmd(op, incr, src, dst, len, pat, hold);
        exp_done = (len == 0) ? 1 : (op ? 3 * int'(len) + 1 : int'(len) + 1);

        n_tests++;
        if (timeout) begin
            n_fail++;
            $display("FAIL %s timeout: cmd_ready not back within %0d cycles", name, ncyc);
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== exp_done) begin
            n_fail++;
            $display("FAIL %s done: %0d pulses, last at cycle %0d; expected 1 pulse at cycle %0d",
                     name, done_cnt, done_cyc, exp_done);
        end
        n_tests++;
        if (ready_cyc !== exp_done + 1) begin
            n_fail++;
            $display("FAIL %s cmd_ready: returned at cycle %0d, expected %0d", name, ready_cyc, exp_done + 1);
        end
        n_tests++;
        if (sum_c1 !== 32'h0) begin
            n_fail++;
            $display("FAIL %s sum_clear: sum=%h in first cycle, expected 0", name, sum_c1);
        end
        n_tests++;
        if (sum_at_done !== ex_sum || sum !== ex_sum) begin
            n_fail++;
            $display("FAIL %s sum: at done %h, after %h, expected %h", name, sum_at_done, sum, ex_sum);
        end
        errs = 0;
        if (wr_addr.size() != ex_wa.size()) errs++;
        else foreach (ex_wa[i]) if (wr_addr[i] !== ex_wa[i] || wr_data[i] !== ex_wd[i]) errs++;
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s writes: %0d observed vs %0d expected, %0d differ",
                     name, wr_addr.size(), ex_wa.size(), errs);
        end
        errs = 0;
        if (rd_addr.size() != ex_ra.size()) errs++;
        else foreach (ex_ra[i]) if (rd_addr[i] !== ex_ra[i]) errs++;
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s reads: %0d observed vs %0d expected, %0d differ",
                     name, rd_addr.size(), ex_ra.size(), errs);
        end
        errs = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (!op) ek = (k <= int'(len)) ? "W" : "-";
            else if (k > 3 * int'(len)) ek = "-";
            else if ((k - 1) % 3 == 0) ek = "R";
            else if ((k - 1) % 3 == 1) ek = "-";
            else ek = "W";
            if (kind_log[k] !== ek) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s bus_order: %0d of %0d cycles had the wrong access kind", name, errs, ncyc);
        end
        if (hold) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s no_reaccept: busy=%b cmd_ready=%b, expected 0/1", name, busy, cmd_ready);
            end
        end
        errs = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) errs++;
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s ram: %0d words differ from the reference image", name, errs);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({cmd_ready, busy, done, avm_chipselect, avm_write, avm_byteenable} !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/busy/done/cs/we/be=%b, expected 100000000",
                     {cmd_ready, busy, done, avm_chipselect, avm_write, avm_byteenable});
        end
        n_tests++;
        if (sum !== 32'h0 || avm_address !== 12'h0 || avm_writedata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: sum=%h addr=%h wdata=%h, expected zeros", sum, avm_address, avm_writedata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || avm_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rdy=%b busy=%b cs=%b, expected 1/0/0", cmd_ready, busy, avm_chipselect);
        end
    endtask

    task automatic test_fill();
        test_command("fill", 1'b0, 1'b1, 12'h000, 12'h010, 13'd4, 32'hA5A50000, 1'b0);
    endtask

    task automatic test_copy();
        test_command("copy", 1'b1, 1'b0, 12'h010, 12'h100, 13'd4, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        test_command("fill_wrap", 1'b0, 1'b0, 12'h000, 12'hFFE, 13'd4, 32'h1, 1'b0);
        test_command("copy_wrap_overlap", 1'b1, 1'b0, 12'hFFD, 12'hFFF, 13'd6, 32'h0, 1'b0);
    endtask

    task automatic test_zero_len();
        test_command("zero_len", 1'b0, 1'b1, 12'h000, 12'h050, 13'd0, 32'h12345678, 1'b1);
    endtask

    task automatic test_busy_ignore();
        test_command("busy_hold", 1'b0, 1'b1, 12'h000, 12'h080, 13'd3, 32'hFFFFFFFE, 1'b1);
    endtask

    task automatic test_full_fill();
        test_command("full_fill", 1'b0, 1'b1, 12'h000, 12'h000, 13'd4096, 32'hFFFFFFFF, 1'b0);
    endtask

    task automatic test_reset_mid();
        int errs;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_incr = 1'b0; cmd_src = 12'h200;
        cmd_dst = 12'h300; cmd_len = 13'd4; cmd_pattern = 32'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        // Cycle 5 is the capture cycle of word 2; reset takes effect at its end.
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({cmd_ready, busy, done, avm_chipselect, avm_write, avm_byteenable} !== 9'b1_0000_0000
            || sum !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: rdy/busy/done/cs/we/be=%b sum=%h, expected 100000000 and 0",
                     {cmd_ready, busy, done, avm_chipselect, avm_write, avm_byteenable}, sum);
        end
        ref_mem[12'h300] = ref_mem[12'h200];
        errs = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy || avm_chipselect) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: %0d cycles with done/busy/cs after reset, expected 0", errs);
        end
        errs = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) errs++;
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL reset_mid_ram: %0d words differ (word 1 kept, word 2 not written)", errs);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            test_command("random", 1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
                         13'($urandom_range(0, 40)), $urandom, 1'($urandom));
        end
    endtask

    initial begin
        reset = 1'b1; ram_init = 1'b1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_incr = 1'b0; cmd_src = '0;
        cmd_dst = '0; cmd_len = '0; cmd_pattern = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_zero_len();
        test_busy_ignore();
        test_full_fill();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
